memory_access_unit: RTL
=======================

# memory_access_unit

Parametrised load/store execution unit for the RISC-V core: computes `input_register1_value + immediate`, performs byte/half/word loads and stores against an internal byte-addressed synchronous RAM or a bank of memory-mapped output channels, and stalls the core until the access completes. It adds two capabilities: split handling of misaligned accesses that cross a word boundary, and precise error reporting for out-of-range, illegal and IO accesses. It sits in the execute stage beside the ALU and drives `result_to_write_rd` into the register-file write mux.

## Interface
- RAM_ADDR_BITS, 8, RAM size is 2^RAM_ADDR_BITS bytes at address 0; must be ≥ 2.
- IO_BASE, 32'h0000_2000, byte address of IO channel 0; channel k is at IO_BASE+k.
- IO_CHANNELS, 4, number of 8-bit output channels (1..16).
- MISALIGNED_SUPPORT, 1, 1 = split misaligned RAM accesses; 0 = raise error.

- clk  in  1  core clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- subfunction_3  in  3  funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- input_register1_value  in  32  base address (rs1).
- input_register2_value  in  32  store data (rs2).
- immediate  in  32  sign-extended offset.
- opcode_is_load  in  1  current instruction is a load.
- opcode_is_store  in  1  current instruction is a store.
- clk_stall  out  1  core must hold inputs stable while high.
- load_error  out  1  load faulted; valid when clk_stall low.
- store_error  out  1  store faulted; valid when clk_stall low.
- result_to_write_rd  out  32  load result, sign/zero extended.
- memory_mapped_io  out  8*IO_CHANNELS  registered channel values, channel k in bits [8k+7:8k].
- io_write_strobe  out  IO_CHANNELS  one-cycle pulse per channel written.

## Operation
- FSM states: IDLE, FIRST, SECOND, DONE.
- IDLE: if load or store asserted, clk_stall=1 (combinational); address A = rs1+imm (mod 2^32); classify; next edge → FIRST, or → DONE with error flag set if faulted.
- Faults (checked before any write, so no partial update): funct3 not in legal set for the op; load and store both high (both errors set); any byte of the access ≥ 2^RAM_ADDR_BITS and not an IO hit; misaligned with MISALIGNED_SUPPORT=0; IO access that is not byte-wide (SH/SW, LH/LW/LHU) or any IO byte outside IO_BASE..IO_BASE+IO_CHANNELS-1.
- IO store: SB writes rs2[7:0] to channel, updates memory_mapped_io on leaving FIRST, pulses its strobe in DONE. IO load (LB/LBU) returns channel value, sign-/zero-extended.
- RAM: word-wide, 4 byte-lane enables, synchronous read. FIRST accesses word containing A; if the access crosses into the next word, SECOND accesses word A+4 aligned. Stores write only enabled lanes; no read-modify-write.
- Little-endian: byte at A is bits [7:0] of the loaded value.
- DONE: clk_stall=0, result/error valid; next edge → IDLE unconditionally.
- Idle with no op: clk_stall=0, errors 0, result holds last value.

## Timing
- Reset (asynchronous, active-low): state IDLE, clk_stall follows inputs combinationally (0 if no op), load_error=0, store_error=0, result_to_write_rd=0, memory_mapped_io=0, io_write_strobe=0. RAM contents not reset.
- Aligned or non-crossing access: clk_stall high 2 cycles (IDLE, FIRST), result in DONE (cycle 3).
- Crossing misaligned access: stall 3 cycles (IDLE, FIRST, SECOND).
- Faulted access: stall 1 cycle (IDLE), error in DONE; errors cleared on return to IDLE.
- result_to_write_rd registered on entry to DONE, held until next load's DONE; stores and faults leave it unchanged.
- Reset asserted mid-operation: returns to IDLE immediately; a crossing store interrupted after FIRST leaves its first word written.
- Back-to-back ops: DONE→IDLE edge consumes instruction; next op stalls from the following IDLE cycle.

## Test plan
- SW FEDCBA98 @FC (EC+10), SH 7654 @FE, SB 32 @FF, LW @FC → 3254BA98, no errors, stall 2 cycles each.
- SW FEDCBA10 @FC; LBU FC..FF → 10, BA, DC, FE; LB @FE → FFFFFFDC; LH @FE → FFFFFEDC; LHU @FC → BA10.
- MISALIGNED_SUPPORT=1: SW 11223344 @F9, LW @F9 → 11223344, stall 3 cycles; LW @FE → load_error=1, RAM unchanged.
- SB D1 @1000+1000 → memory_mapped_io[7:0]=D1, io_write_strobe=0001 for one cycle in DONE; SW @2000 → store_error=1, channels unchanged.
- funct3=011 load → load_error=1; load+store both high → both errors, no write; MISALIGNED_SUPPORT=0 LH @FD → load_error=1.
- reset_n low during SECOND of crossing store → outputs reset values within same cycle, state IDLE, clk_stall 0 with no op.

Source files
------------

// File: rtl/memory_access_unit.sv
// Load/store execution unit: byte-addressed synchronous RAM plus memory-mapped 8-bit output
// channels. Misaligned RAM accesses that cross a word are split, and faults are reported.
module memory_access_unit #(
  parameter int unsigned RAM_ADDR_BITS      = 8,
  parameter logic [31:0] IO_BASE            = 32'h0000_2000,
  parameter int unsigned IO_CHANNELS        = 4,
  parameter bit          MISALIGNED_SUPPORT = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               subfunction_3,
  input  logic [31:0]              input_register1_value,
  input  logic [31:0]              input_register2_value,
  input  logic [31:0]              immediate,
  input  logic                     opcode_is_load,
  input  logic                     opcode_is_store,
  output logic                     clk_stall,
  output logic                     load_error,
  output logic                     store_error,
  output logic [31:0]              result_to_write_rd,
  output logic [8*IO_CHANNELS-1:0] memory_mapped_io,
  output logic [IO_CHANNELS-1:0]   io_write_strobe
);

  localparam int unsigned Words    = 1 << (RAM_ADDR_BITS - 2);
  localparam int unsigned IdxW     = (RAM_ADDR_BITS > 2) ? RAM_ADDR_BITS - 2 : 1;
  localparam int unsigned ChW      = (IO_CHANNELS > 1) ? $clog2(IO_CHANNELS) : 1;
  localparam logic [32:0] RamLimit = 33'd1 << RAM_ADDR_BITS;
  localparam logic [32:0] IoLo     = {1'b0, IO_BASE};
  localparam logic [32:0] IoHi     = {1'b0, IO_BASE} + 33'(IO_CHANNELS);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond, StDone} state_e;
  state_e state_q, state_d;

  logic                         op, both, legal, load_legal, store_legal;
  logic                         io_touch, io_hit, in_ram, misal, fault, crossing;
  logic                         is_load, ram_store, io_store;
  logic [31:0]                  addr;
  logic [1:0]                   off, align_mask;
  logic [2:0]                   size;
  logic [3:0]                   size_mask;
  logic [32:0]                  last;
  logic [ChW-1:0]               io_idx;
  logic [IO_CHANNELS-1:0]       io_onehot;
  logic [7:0]                   be_wide;
  logic [63:0]                  wdata_wide, window;
  logic [IdxW-1:0]              word0_idx, word1_idx, rd_idx, wr_idx;
  logic                         wr_en, io_write, cap_result;
  logic [3:0]                   wr_be;
  logic [31:0]                  wr_data, raw, load_value;
  logic [31:0]                  mem [Words];
  logic [31:0]                  rdata_q, lo_q, result_q;
  logic                         ld_err_q, st_err_q;
  logic [IO_CHANNELS-1:0][7:0]  chan_q;
  logic [IO_CHANNELS-1:0]       strobe_q;

  assign op          = opcode_is_load | opcode_is_store;
  assign both        = opcode_is_load & opcode_is_store;
  assign addr        = input_register1_value + immediate;
  assign off         = addr[1:0];
  assign load_legal  = (subfunction_3[1:0] != 2'b11) && (subfunction_3 != 3'b110);
  assign store_legal = !subfunction_3[2] && (subfunction_3[1:0] != 2'b11);
  assign legal       = opcode_is_load ? load_legal : store_legal;

  always_comb begin
    unique case (subfunction_3[1:0])
      2'b00:   begin size = 3'd1; size_mask = 4'b0001; align_mask = 2'b00; end
      2'b01:   begin size = 3'd2; size_mask = 4'b0011; align_mask = 2'b01; end
      default: begin size = 3'd4; size_mask = 4'b1111; align_mask = 2'b11; end
    endcase
  end

  // Classification uses the whole byte span so any byte outside a region faults.
  assign last     = {1'b0, addr} + {30'b0, size} - 33'd1;
  assign io_touch = ({1'b0, addr} < IoHi) && (last >= IoLo);
  assign io_hit   = io_touch && (size == 3'd1);
  assign in_ram   = last < RamLimit;
  assign misal    = |(off & align_mask);
  assign fault    = both || !legal || (io_touch && !io_hit) || (!io_touch && !in_ram) ||
                    (!io_touch && misal && !MISALIGNED_SUPPORT);

  assign io_idx    = ChW'(addr - IO_BASE);
  assign io_onehot = IO_CHANNELS'(1) << io_idx;
  assign is_load   = opcode_is_load & !opcode_is_store;
  assign ram_store = opcode_is_store & !opcode_is_load & !io_hit;
  assign io_store  = opcode_is_store & !opcode_is_load & io_hit;

  // Access laid across two consecutive words; the upper half belongs to the second word.
  assign be_wide    = 8'({4'b0, size_mask} << off);
  assign wdata_wide = 64'({32'b0, input_register2_value} << {off, 3'b000});
  assign crossing   = |be_wide[7:4];
  assign word0_idx  = addr[IdxW+1:2];
  assign word1_idx  = word0_idx + IdxW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (op) state_d = fault ? StDone : StFirst;
      StFirst:  state_d = (crossing && !io_hit) ? StSecond : StDone;
      StSecond: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // RAM reads are issued one state ahead of where the data is consumed.
  always_comb begin
    clk_stall  = 1'b0;
    rd_idx     = word0_idx;
    wr_en      = 1'b0;
    wr_idx     = word0_idx;
    wr_be      = be_wide[3:0];
    wr_data    = wdata_wide[31:0];
    io_write   = 1'b0;
    cap_result = 1'b0;
    unique case (state_q)
      StIdle: clk_stall = op;
      StFirst: begin
        clk_stall  = 1'b1;
        rd_idx     = word1_idx;
        wr_en      = ram_store;
        io_write   = io_store;
        cap_result = is_load && (state_d == StDone);
      end
      StSecond: begin
        clk_stall  = 1'b1;
        wr_en      = ram_store;
        wr_idx     = word1_idx;
        wr_be      = be_wide[7:4];
        wr_data    = wdata_wide[63:32];
        cap_result = is_load;
      end
      default: ;
    endcase
  end

  always_comb begin
    window = (state_q == StSecond) ? {rdata_q, lo_q} : {32'b0, rdata_q};
    raw    = io_hit ? {24'b0, chan_q[io_idx]} : 32'(window >> {off, 3'b000});
    unique case (subfunction_3[1:0])
      2'b00:   load_value = {{24{!subfunction_3[2] & raw[7]}}, raw[7:0]};
      2'b01:   load_value = {{16{!subfunction_3[2] & raw[15]}}, raw[15:0]};
      default: load_value = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    rdata_q <= mem[rd_idx];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q     <= '0;
      result_q <= '0;
      ld_err_q <= 1'b0;
      st_err_q <= 1'b0;
      chan_q   <= '0;
      strobe_q <= '0;
    end else begin
      ld_err_q <= (state_q == StIdle) && fault && opcode_is_load;
      st_err_q <= (state_q == StIdle) && fault && opcode_is_store;
      strobe_q <= io_write ? io_onehot : '0;
      if (io_write) chan_q[io_idx] <= input_register2_value[7:0];
      if (state_q == StFirst) lo_q <= rdata_q;
      if (cap_result) result_q <= load_value;
    end
  end

  assign load_error         = ld_err_q;
  assign store_error        = st_err_q;
  assign result_to_write_rd = result_q;
  assign memory_mapped_io   = chan_q;
  assign io_write_strobe    = strobe_q;

endmodule
